piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Takes a width_p-bit word over a valid/ready handshake and emits it one bit per accepted beat on a serial valid/ready port.
- It drives the serial bit streams that the team's per-bit capture flops and deserializers consume on the far end.
- Supports stall (back-pressure) and back-to-back words with no idle cycle.

Parameters:
- width_p, 8, parallel word width in bits; legal range 2..64.
- lsb_first_p, 1'b1, 1 = bit 0 is sent first, 0 = bit width_p-1 is sent first.

Ports:
- clk_i  input  1  clock, all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  parallel word valid.
- data_i  input  width_p  parallel word; sampled only on an accept.
- ready_o  output  1  block can accept a parallel word this cycle.
- valid_o  output  1  serial bit valid.
- data_o  output  1  serial bit.
- last_o  output  1  current serial beat is the final beat of the word.
- ready_i  input  1  downstream accepts the serial beat this cycle.

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - State goes to IDLE; shift register, beat counter and parity accumulator clear to 0.
  - Outputs during reset: valid_o=0, data_o=0, last_o=0, ready_o=1.
- States: IDLE, SHIFT. The enum lives in the package.
- IDLE:
  - ready_o=1, valid_o=0.
  - Accept = valid_i & ready_o. On accept: load data_i into the shift register, count=0, go to SHIFT.
- SHIFT:
  - valid_o=1; data_o = current head bit (bit 0 if lsb_first_p, else bit width_p-1).
  - Beats total N = width_p (N = width_p+1 with PARITY_EN). last_o=1 when count==N-1.
  - ready_i=1 on a non-last beat: shift the register toward the head, count++.
  - ready_i=0 (stall): data_o, last_o, count and the shift register all hold. The value must be stable while valid_o=1.
- Final beat handshake:
  - ready_o = (state==IDLE) | (state==SHIFT & last_o & ready_i). This is a combinational path from ready_i and is documented at the top level.
  - Last beat taken with a new accept the same cycle: load the new word, count=0, stay in SHIFT. This gives zero bubbles, so throughput is 1 bit/cycle sustained.
  - Last beat taken with no accept: go to IDLE.
- Latency:
  - The first serial bit is valid the cycle after the accept.
  - A non-stalled word occupies exactly N cycles.
- Width rules:
  - Counter width is $clog2(width_p+1), so the parity beat fits.
  - The counter never wraps past N-1; it resets to 0 on reload.
- valid_i while busy and not on an accepted last beat: ignored (ready_o=0). The upstream must hold data_i until ready_o.
- Reset mid-word: the word is dropped and no partial-word completion occurs. After release: IDLE, ready_o=1.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - An extra beat follows the data bits, carrying even parity (XOR of all width_p data bits).
  - last_o asserts on the parity beat, not on the final data bit.
  - N = width_p+1.
  - A 1-bit accumulator is cleared on load and XORs in each data bit as it is accepted.
- Undefined: no parity logic; N = width_p; last_o on the final data bit.

Decomposition:
- Package piso_pkg:
  - state typedef (enum logic [0:0] {IDLE, SHIFT}).
  - localparam function for counter width.
- Sub-module piso_beat_counter:
  - Parameterized max_p; ports clk_i, reset_i, clear_i, up_i, count_o, last_o.
  - Async active-high reset.
  - Instantiated once with max_p = N-1.
- Shift register and FSM stay in the top module.

Test Plan:
- Single word, no stall: width_p=8, lsb_first_p=1, data_i=8'hA5 accepted at cycle 0, ready_i=1.
  -> data_o sequence 1,0,1,0,0,1,0,1 on cycles 1..8; last_o only on cycle 8; ready_o=1 from cycle 9.
- MSB first: lsb_first_p=0, data_i=8'h81.
  -> sequence 1,0,0,0,0,0,0,1.
- Stall: ready_i=0 for 3 cycles after beat 2 of 8'h3C.
  -> data_o and last_o frozen; the remaining bits are unchanged and in order; total 11 cycles.
- Back-to-back: 8'hFF then 8'h00, valid_i held, ready_i=1.
  -> 16 contiguous valid_o cycles; ready_o pulses exactly on cycle 8; no bubble.
- Reset mid-word: assert reset_i asynchronously between edges during beat 4 of 8'hF0.
  -> valid_o=0 and ready_o=1 immediately; after release, a new word 8'h01 serializes correctly from bit 0.
- Parity (macro defined): data_i=8'h07.
  -> 9 beats; the 9th bit is 1; last_o only on beat 9. With 8'h03, the 9th bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serializer block.
// Optional feature macro used by the block: PISO_SERIALIZER_PARITY_EN.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Beat counter width: wide enough to hold width_p, so a trailing parity beat fits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_beat_counter.sv
// Beat counter for piso_serializer: counts accepted beats and flags the final one.
module piso_beat_counter
    import piso_pkg::*;
#(
    parameter int unsigned max_p   = 7,
    parameter int unsigned cnt_w_p = cnt_width(max_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [cnt_w_p-1:0] count_o,
    output logic               last_o
);

    localparam logic [cnt_w_p-1:0] max_lp = cnt_w_p'(max_p);

    logic [cnt_w_p-1:0] count_q;
    logic [cnt_w_p-1:0] count_d;

    // Next count: clear has priority, and the count saturates at max_p.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i && (count_q != max_lp)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == max_lp);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready on both sides.
// Optional macro PISO_SERIALIZER_PARITY_EN appends an even-parity beat to each word.
// Note: ready_o depends combinationally on ready_i, which allows a new word to
// load on the same edge that the final beat of the previous word is taken.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned width_p     = 8,
    parameter logic        lsb_first_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic               data_o,
    output logic               last_o,
    input  logic               ready_i
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int unsigned beats_lp = width_p + 1;
`else
    localparam int unsigned beats_lp = width_p;
`endif
    localparam int unsigned cnt_w_lp = cnt_width(width_p);

    state_e             state_q, state_d;
    logic [width_p-1:0] shreg_q, shreg_d;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic                cnt_clear;
    logic                cnt_up;
    logic                cnt_last;
    logic [cnt_w_lp-1:0] cnt_value;
    logic                in_shift;
    logic                head_bit;
    logic [width_p-1:0]  shifted;
    logic                accept;

    piso_beat_counter #(
        .max_p   (beats_lp - 1),
        .cnt_w_p (cnt_w_lp)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .up_i    (cnt_up),
        .count_o (cnt_value),
        .last_o  (cnt_last)
    );

    assign in_shift = (state_q == SHIFT);
    assign head_bit = lsb_first_p ? shreg_q[0] : shreg_q[width_p-1];
    assign shifted  = lsb_first_p ? {1'b0, shreg_q[width_p-1:1]}
                                  : {shreg_q[width_p-2:0], 1'b0};

    assign valid_o = in_shift;
    assign last_o  = in_shift & cnt_last;
`ifdef PISO_SERIALIZER_PARITY_EN
    assign data_o  = in_shift & (cnt_last ? parity_q : head_bit);
`else
    assign data_o  = in_shift & head_bit;
`endif
    assign ready_o = (state_q == IDLE) | (last_o & ready_i);
    assign accept  = valid_i & ready_o;

    // Next-state, shift and counter control; all defaults hold the current word.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        cnt_clear = 1'b0;
        cnt_up    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = data_i;
`ifdef PISO_SERIALIZER_PARITY_EN
                    parity_d  = 1'b0;
`endif
                    cnt_clear = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ready_i) begin
                    if (cnt_last) begin
                        cnt_clear = 1'b1;
                        if (accept) begin
                            shreg_d  = data_i;
`ifdef PISO_SERIALIZER_PARITY_EN
                            parity_d = 1'b0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d  = shifted;
                        cnt_up   = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                        parity_d = parity_q ^ head_bit;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shift register and parity registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LSB-first and one MSB-first instance share stimulus.
// Expectations follow PISO_SERIALIZER_PARITY_EN when the macro is defined.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] lsb_seq;   // bit i = expected serial bit on beat i, LSB-first
        logic [7:0] msb_seq;   // bit i = expected serial bit on beat i, MSB-first
        logic       par;       // expected parity beat
        int         stall_at;  // beat index that stalls, -1 for none
        int         stall_len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_i;
    logic       l_ready, l_valid, l_data, l_last;
    logic       m_ready, m_valid, m_data, m_last;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.width_p(8), .lsb_first_p(1'b1)) u_lsb (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(l_ready), .valid_o(l_valid), .data_o(l_data), .last_o(l_last),
        .ready_i(ready_i)
    );

    piso_serializer #(.width_p(8), .lsb_first_p(1'b0)) u_msb (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(m_ready), .valid_o(m_valid), .data_o(m_data), .last_o(m_last),
        .ready_i(ready_i)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic el,
                             input logic em, input logic elast, input logic erdy);
        chk({tag, " lsb valid"}, l_valid, ev);
        chk({tag, " lsb data"},  l_data,  el);
        chk({tag, " lsb last"},  l_last,  elast);
        chk({tag, " lsb ready"}, l_ready, erdy);
        chk({tag, " msb valid"}, m_valid, ev);
        chk({tag, " msb data"},  m_data,  em);
        chk({tag, " msb last"},  m_last,  elast);
        chk({tag, " msb ready"}, m_ready, erdy);
    endtask

    // Called at posedge+1; returns at posedge+1 with both instances idle.
    task automatic run_row(input vec_t v, input int r);
        logic [7:0] ls, ms;
        logic       el, em;
        ls = v.lsb_seq;
        ms = v.msb_seq;
        valid_i = 1'b1;
        data_i  = v.data;
        ready_i = 1'b1;
        @(negedge clk);
        check_all($sformatf("row%0d accept", r), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            el = (b < 8) ? ls[b] : v.par;
            em = (b < 8) ? ms[b] : v.par;
            if (b == v.stall_at) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    ready_i = 1'b0;
                    @(negedge clk);
                    check_all($sformatf("row%0d stall b%0d s%0d", r, b, s),
                              1'b1, el, em, (b == NB-1), 1'b0);
                    @(posedge clk); #1;
                end
            end
            ready_i = 1'b1;
            if (b == 1) begin
                valid_i = 1'b1;
                data_i  = ~v.data;
            end
            @(negedge clk);
            check_all($sformatf("row%0d beat%0d", r, b), 1'b1, el, em, (b == NB-1), (b == NB-1));
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
        @(negedge clk);
        check_all($sformatf("row%0d idle", r), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[6];
    vec_t v01;

    initial begin
        logic e;
        vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0, -1, 0};
        vecs[1] = '{8'h81, 8'h81, 8'h81, 1'b0, -1, 0};
        vecs[2] = '{8'h3C, 8'h3C, 8'h3C, 1'b0,  2, 3};
        vecs[3] = '{8'hC2, 8'hC2, 8'h43, 1'b1, -1, 0};
        vecs[4] = '{8'h07, 8'h07, 8'hE0, 1'b1,  5, 2};
        vecs[5] = '{8'h03, 8'h03, 8'hC0, 1'b0, -1, 0};
        v01     = '{8'h01, 8'h01, 8'h80, 1'b1, -1, 0};

        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b1;
        @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check_all("post reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) run_row(vecs[r], r);

        // Back-to-back 8'hFF then 8'h00 with no bubble; both parities are 0.
        valid_i = 1'b1;
        data_i  = 8'hFF;
        @(negedge clk);
        check_all("b2b accept", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < NB; b++) begin
                e = (w == 0 && b < 8) ? 1'b1 : 1'b0;
                if (w == 0 && b == NB-1) begin
                    valid_i = 1'b1;
                    data_i  = 8'h00;
                end
                @(negedge clk);
                check_all($sformatf("b2b w%0d b%0d", w, b), 1'b1, e, e, (b == NB-1), (b == NB-1));
                @(posedge clk); #1;
                valid_i = 1'b0;
            end
        end
        @(negedge clk);
        check_all("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Reset during beat index 3 of 8'hF0, then a clean 8'h01.
        valid_i = 1'b1;
        data_i  = 8'hF0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check_all($sformatf("rst word b%0d", b), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        #2 reset_i = 1'b1;
        #1;
        check_all("mid-word reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check_all("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        run_row(v01, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
